// File: rtl/parity_stream_gen_chk_pkg.sv
// Shared types and constants for the parity stream generator/checker.
`timescale 1ns/1ps
package parity_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_stream_gen_chk_if.sv
// Stream-in / stream-out handshake bundle; slave is the block side, master the source/sink side.
`timescale 1ns/1ps
interface parity_stream_gen_chk_if #(
  parameter int DATA_W = 8
) ();

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_par;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_par;
  logic              m_err;
  logic              m_last;

  modport slave (
    input  s_valid, s_data, s_par, s_last, m_ready,
    output s_ready, m_valid, m_data, m_par, m_err, m_last
  );

  modport master (
    output s_valid, s_data, s_par, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_par, m_err, m_last
  );

endinterface

// File: rtl/parity_stream_gen_chk_parity_calc.sv
// Combinational parity generation and received-parity check for one beat.
`timescale 1ns/1ps
module parity_calc
  import parity_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              par_in,
  input  logic              mode,
  output logic              gen_par,
  output logic              err
);

  // Odd mode flips the sense of both the generated bit and the check.
  always_comb begin
    gen_par = (^data) ^ (mode == PAR_ODD);
    err     = (^data) ^ par_in ^ (mode == PAR_ODD);
  end

endmodule

// File: rtl/parity_stream_gen_chk.sv
// One-stage registered stream with per-beat parity generate/check, frame summary and error counter.
`timescale 1ns/1ps
module parity_stream_gen_chk
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   odd_mode,
  input  logic                   clr_cnt,
  parity_stream_gen_chk_if.slave bus,
  output logic                   frame_done,
  output logic                   frame_par,
  output logic                   frame_err,
  output logic [CNT_W-1:0]       err_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_r;
  logic              mode_r;
  logic              acc_par_r;
  logic              acc_err_r;
  logic              m_valid_r;
  logic [DATA_W-1:0] m_data_r;
  logic              m_par_r;
  logic              m_err_r;
  logic              m_last_r;
  logic              frame_done_r;
  logic              frame_par_r;
  logic              frame_err_r;
  logic [CNT_W-1:0]  err_cnt_r;

  logic s_ready_s;
  logic accept_s;
  logic mode_s;
  logic beat_par_s;
  logic beat_err_s;
  logic frame_par_s;
  logic frame_err_s;

  parity_calc #(.DATA_W(DATA_W)) u_calc (
    .data    (bus.s_data),
    .par_in  (bus.s_par),
    .mode    (mode_s),
    .gen_par (beat_par_s),
    .err     (beat_err_s)
  );

  // Handshake and frame mode: the first beat uses the live mode input, later beats the latched one.
  always_comb begin
    s_ready_s = !m_valid_r || bus.m_ready;
    accept_s  = bus.s_valid && s_ready_s;
    if (state_r == IDLE) begin
      mode_s = odd_mode;
    end else begin
      mode_s = mode_r;
    end
    // acc_par_r holds pure data parity so the mode is applied exactly once.
    frame_par_s = acc_par_r ^ beat_par_s;
    frame_err_s = acc_err_r | beat_err_s;
  end

  // Output register stage; holds while the sink stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_r <= 1'b0;
      m_data_r  <= '0;
      m_par_r   <= 1'b0;
      m_err_r   <= 1'b0;
      m_last_r  <= 1'b0;
    end else if (accept_s) begin
      m_valid_r <= 1'b1;
      m_data_r  <= bus.s_data;
      m_par_r   <= beat_par_s;
      m_err_r   <= beat_err_s;
      m_last_r  <= bus.s_last;
    end else if (bus.m_ready) begin
      m_valid_r <= 1'b0;
    end
  end

  // Frame FSM with parity/error accumulation and the registered frame summary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      mode_r       <= PAR_EVEN;
      acc_par_r    <= 1'b0;
      acc_err_r    <= 1'b0;
      frame_done_r <= 1'b0;
      frame_par_r  <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (accept_s) begin
        case (state_r)
          IDLE:     mode_r <= odd_mode;
          IN_FRAME: mode_r <= mode_r;
          default:  mode_r <= PAR_EVEN;
        endcase
        if (bus.s_last) begin
          state_r      <= IDLE;
          acc_par_r    <= 1'b0;
          acc_err_r    <= 1'b0;
          frame_done_r <= 1'b1;
          frame_par_r  <= frame_par_s;
          frame_err_r  <= frame_err_s;
        end else begin
          state_r   <= IN_FRAME;
          acc_par_r <= acc_par_r ^ beat_par_s ^ mode_s;
          acc_err_r <= frame_err_s;
        end
      end
    end
  end

  // Saturating error counter; clear takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_r <= '0;
    end else if (clr_cnt) begin
      err_cnt_r <= '0;
    end else if (accept_s && beat_err_s && (err_cnt_r != CNT_MAX)) begin
      err_cnt_r <= err_cnt_r + CNT_ONE;
    end
  end

  assign bus.s_ready = s_ready_s;
  assign bus.m_valid = m_valid_r;
  assign bus.m_data  = m_data_r;
  assign bus.m_par   = m_par_r;
  assign bus.m_err   = m_err_r;
  assign bus.m_last  = m_last_r;
  assign frame_done  = frame_done_r;
  assign frame_par   = frame_par_r;
  assign frame_err   = frame_err_r;
  assign err_cnt     = err_cnt_r;

endmodule
